pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Sequences the program counter of the single-cycle MIPS core. It owns the PC register, computes PC+4 and the branch and jump targets, and drives the select of the PC input mux.
- Adds boot delay, stall/hold, halt/resume and an illegal-control trap around the basic next-PC selection.
- Sits between the main control decoder / ALU zero flag and the instruction memory address port.

Parameters:
- ADDR_WIDTH, 32, width of PC and all address ports; must be ≥ 32.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0180, PC value loaded on entry to TRAP.
- BOOT_CYCLES, 2, number of cycles spent in BOOT after reset release; legal range 1..15.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- STALL  in  1  hold PC this cycle (RUN only).
- BRANCH  in  1  beq decoded.
- ZERO  in  1  ALU zero flag.
- JUMP  in  1  j decoded.
- IMM_EXT  in  ADDR_WIDTH  sign-extended 16-bit immediate.
- JUMP_INDEX  in  26  instr[25:0].
- HALT_REQ  in  1  request halt.
- RESUME  in  1  leave HALT/TRAP.
- PC  out  ADDR_WIDTH  current fetch address (registered).
- PC_Plus_4  out  ADDR_WIDTH  PC + 4, combinational.
- PC_SRC_SEL  out  1  branch-taken select to the PC input mux.
- INSTR_VALID  out  1  current instruction is to be executed/retired.
- STATE  out  2  BOOT=0, RUN=1, HALT=2, TRAP=3.
- TRAP_ERR  out  1  sticky illegal-control flag.
- INSTR_COUNT  out  32  retired-instruction counter.

Behaviour:
- Reset (RST_N low, asynchronous):
  - PC=RESET_VECTOR, STATE=BOOT, boot counter=0, TRAP_ERR=0, INSTR_COUNT=0.
  - Combinational outputs follow from these values: INSTR_VALID=0, PC_SRC_SEL=0.
- Address arithmetic:
  - PC_Plus_4 = PC + 4, modulo 2^ADDR_WIDTH; no overflow flag.
  - Branch target = PC_Plus_4 + (IMM_EXT << 2), modulo 2^ADDR_WIDTH.
  - Jump target = {PC_Plus_4[ADDR_WIDTH-1:28], JUMP_INDEX, 2'b00}.
- BOOT:
  - PC holds RESET_VECTOR; INSTR_VALID=0; boot counter increments each cycle.
  - When counter == BOOT_CYCLES-1, go to RUN next edge.
  - All other inputs are ignored.
- RUN, evaluated in priority order each edge:
  1. BRANCH & JUMP both 1: illegal. PC<=TRAP_VECTOR, STATE<=TRAP, TRAP_ERR<=1. No count increment.
  2. STALL=1: PC holds, no count increment. HALT_REQ is ignored while stalled.
  3. HALT_REQ=1: PC<=next PC (current instruction retires), INSTR_COUNT+1, STATE<=HALT.
  4. Otherwise: PC<=next PC, INSTR_COUNT+1.
  - Next-PC selection: JUMP → jump target; else BRANCH&ZERO → branch target; else PC_Plus_4.
- Combinational outputs:
  - INSTR_VALID = (STATE==RUN) & ~STALL & ~(BRANCH&JUMP).
  - PC_SRC_SEL = INSTR_VALID & BRANCH & ZERO & ~JUMP.
- HALT:
  - PC holds; INSTR_VALID=0.
  - RESUME=1 → RUN next edge, fetching from the held PC.
  - HALT_REQ is ignored while in HALT.
- TRAP:
  - PC holds TRAP_VECTOR; INSTR_VALID=0.
  - RESUME=1 → RUN next edge, fetching from TRAP_VECTOR.
  - TRAP_ERR stays 1 until reset.
- INSTR_COUNT wraps from 0xFFFF_FFFF to 0.
- Reset asserted mid-operation takes effect immediately, from any state.
- On reset release, the first RUN cycle is BOOT_CYCLES edges later.
- One state transition per edge; no combinational path from RESUME or HALT_REQ to PC.

Test Plan:
- Reset release, BOOT_CYCLES=2, no control inputs → STATE 0,0 then 1. PC=0,0,0,4,8,... INSTR_COUNT increments from the first RUN edge.
- RUN at PC=0x40, BRANCH=1, ZERO=1, IMM_EXT=0xFFFF_FFFC → PC_SRC_SEL=1, next PC=0x44-0x10=0x34. Repeat with ZERO=0 → PC_SRC_SEL=0, next PC=0x44.
- PC=0x1000_0000, JUMP=1, JUMP_INDEX=0x0000100 → next PC=0x1000_0400, PC_SRC_SEL=0.
- STALL high 3 cycles at PC=0x20 → PC stays 0x20, INSTR_VALID=0, count unchanged. Release → 0x24.
- HALT_REQ at PC=0x8 → PC=0xC, STATE=2, PC holds 5 cycles. RESUME → STATE=1, next PC=0x10.
- BRANCH=JUMP=1 at PC=0x50 → PC=0x180, STATE=3, TRAP_ERR=1. RESUME → fetch 0x180, 0x184, TRAP_ERR stays 1. Assert RST_N=0 mid-TRAP → immediate PC=0, STATE=0, TRAP_ERR=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS core: owns the PC,
// builds PC+4 / branch / jump targets and wraps them in a boot/run/halt/trap FSM.
module pc_sequencer #(
   parameter int unsigned              ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0]    TRAP_VECTOR  = 32'h0000_0180,
   parameter int unsigned              BOOT_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  branch,
   input  logic                  zero,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] imm_ext,
   input  logic [25:0]           jump_index,
   input  logic                  halt_req,
   input  logic                  resume,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] pc_plus_4,
   output logic                  pc_src_sel,
   output logic                  instr_valid,
   output logic [1:0]            state,
   output logic                  trap_err,
   output logic [31:0]           instr_count
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2,
      TRAP = 2'd3
   } state_t;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_t                cur_state, nxt_state;
   logic [3:0]            boot_cnt, boot_cnt_nxt;
   logic [ADDR_WIDTH-1:0] pc_nxt;
   logic [ADDR_WIDTH-1:0] branch_target, jump_target, fetch_next;
   logic [31:0]           count_nxt;
   logic                  trap_nxt;
   logic                  illegal;

   assign pc_plus_4     = pc + ADDR_WIDTH'(4);
   assign branch_target = pc_plus_4 + (imm_ext << 2);
   assign jump_target   = {pc_plus_4[ADDR_WIDTH-1:28], jump_index, 2'b00};
   assign illegal       = branch & jump;

   assign fetch_next = jump              ? jump_target   :
                       (branch & zero)   ? branch_target :
                                           pc_plus_4;

   assign instr_valid = (cur_state == RUN) & ~stall & ~illegal;
   assign pc_src_sel  = instr_valid & branch & zero & ~jump;
   assign state       = cur_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state   <= BOOT;
         boot_cnt    <= 4'd0;
         pc          <= RESET_VECTOR;
         trap_err    <= 1'b0;
         instr_count <= 32'd0;
      end else begin
         cur_state   <= nxt_state;
         boot_cnt    <= boot_cnt_nxt;
         pc          <= pc_nxt;
         trap_err    <= trap_nxt;
         instr_count <= count_nxt;
      end
   end

   // RUN priority: illegal control beats stall, stall beats halt request.
   always_comb begin
      nxt_state    = cur_state;
      boot_cnt_nxt = boot_cnt;
      pc_nxt       = pc;
      trap_nxt     = trap_err;
      count_nxt    = instr_count;
      unique case (cur_state)
         BOOT: begin
            pc_nxt       = RESET_VECTOR;
            boot_cnt_nxt = boot_cnt + 4'd1;
            if (boot_cnt == BOOT_LAST) begin
               nxt_state = RUN;
            end
         end
         RUN: begin
            if (illegal) begin
               pc_nxt    = TRAP_VECTOR;
               nxt_state = TRAP;
               trap_nxt  = 1'b1;
            end else if (!stall) begin
               pc_nxt    = fetch_next;
               count_nxt = instr_count + 32'd1;
               if (halt_req) begin
                  nxt_state = HALT;
               end
            end
         end
         HALT: begin
            if (resume) begin
               nxt_state = RUN;
            end
         end
         TRAP: begin
            pc_nxt = TRAP_VECTOR;
            if (resume) begin
               nxt_state = RUN;
            end
         end
         default: nxt_state = BOOT;
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: per-cycle vectors with a queue of
// expected post-edge register values, plus a hand-written mid-trap reset check.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
   logic [31:0] immExt = 32'd0;
   logic [25:0] jumpIndex = 26'd0;
   logic        haltReq = 1'b0, resume = 1'b0;
   logic [31:0] pc, pcPlus4, instrCount;
   logic        pcSrcSel, instrValid, trapErr;
   logic [1:0]  state;

   int passCount = 0;
   int checkCount = 0;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
      .jump(jump), .imm_ext(immExt), .jump_index(jumpIndex),
      .halt_req(haltReq), .resume(resume), .pc(pc), .pc_plus_4(pcPlus4),
      .pc_src_sel(pcSrcSel), .instr_valid(instrValid), .state(state),
      .trap_err(trapErr), .instr_count(instrCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st, br, z, j;
      logic [31:0] imm;
      logic [25:0] jidx;
      logic        hr, rs;
      logic        xValid, xSrc;
      logic [31:0] xPc4;
      logic [31:0] xPc;
      logic [1:0]  xState;
      logic        xTrap;
      logic [31:0] xCnt;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  state;
      logic        trap;
      logic [31:0] cnt;
   } exp_t;

   vec_t vecs[30];
   exp_t expQ[$];

   function automatic vec_t mk(input logic st, br, z, j, input logic [31:0] imm,
                               input logic [25:0] jidx, input logic hr, rs,
                               input logic xValid, xSrc, input logic [31:0] xPc4,
                               input logic [31:0] xPc, input logic [1:0] xState,
                               input logic xTrap, input logic [31:0] xCnt);
      vec_t v;
      v.st = st; v.br = br; v.z = z; v.j = j; v.imm = imm; v.jidx = jidx;
      v.hr = hr; v.rs = rs; v.xValid = xValid; v.xSrc = xSrc; v.xPc4 = xPc4;
      v.xPc = xPc; v.xState = xState; v.xTrap = xTrap; v.xCnt = xCnt;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Drive one vector, check the combinational outputs before the edge and the
   // registered outputs after it; returns at the following falling edge.
   task automatic applyStimulus(input int idx);
      vec_t v;
      exp_t e;
      exp_t got;
      v = vecs[idx];
      stall = v.st; branch = v.br; zero = v.z; jump = v.j;
      immExt = v.imm; jumpIndex = v.jidx; haltReq = v.hr; resume = v.rs;
      #1;
      checkOutput($sformatf("v%0d instr_valid", idx), 32'(instrValid), 32'(v.xValid));
      checkOutput($sformatf("v%0d pc_src_sel", idx), 32'(pcSrcSel), 32'(v.xSrc));
      checkOutput($sformatf("v%0d pc_plus_4", idx), pcPlus4, v.xPc4);
      e.pc = v.xPc; e.state = v.xState; e.trap = v.xTrap; e.cnt = v.xCnt;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkCount++;
      if (expQ.size() == 0) begin
         $display("[TB] FAIL v%0d scoreboard: got empty queue, expected an entry", idx);
      end else begin
         passCount++;
         got = expQ.pop_front();
         checkOutput($sformatf("v%0d pc", idx), pc, got.pc);
         checkOutput($sformatf("v%0d state", idx), 32'(state), 32'(got.state));
         checkOutput($sformatf("v%0d trap_err", idx), 32'(trapErr), 32'(got.trap));
         checkOutput($sformatf("v%0d instr_count", idx), instrCount, got.cnt);
      end
      @(negedge clk);
   endtask

   initial begin
      //                st br z  j  imm           jidx     hr rs  v  s  pc4            pc             st tr cnt
      vecs[0]  = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 0,  0, 0, 32'h4,        32'h0,         0, 0, 0);
      vecs[1]  = mk(0, 1, 1, 1, 32'h0,        26'h0,   1, 0,  0, 0, 32'h4,        32'h0,         1, 0, 0);
      vecs[2]  = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 0,  1, 0, 32'h4,        32'h4,         1, 0, 1);
      vecs[3]  = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 0,  1, 0, 32'h8,        32'h8,         1, 0, 2);
      vecs[4]  = mk(0, 0, 0, 0, 32'h0,        26'h0,   1, 0,  1, 0, 32'hC,        32'hC,         2, 0, 3);
      vecs[5]  = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 0,  0, 0, 32'h10,       32'hC,         2, 0, 3);
      vecs[6]  = mk(0, 0, 0, 0, 32'h0,        26'h0,   1, 0,  0, 0, 32'h10,       32'hC,         2, 0, 3);
      vecs[7]  = mk(0, 1, 1, 0, 32'h0,        26'h0,   0, 0,  0, 0, 32'h10,       32'hC,         2, 0, 3);
      vecs[8]  = mk(0, 0, 0, 1, 32'h0,        26'h8,   0, 0,  0, 0, 32'h10,       32'hC,         2, 0, 3);
      vecs[9]  = mk(1, 0, 0, 0, 32'h0,        26'h0,   0, 0,  0, 0, 32'h10,       32'hC,         2, 0, 3);
      vecs[10] = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 1,  0, 0, 32'h10,       32'hC,         1, 0, 3);
      vecs[11] = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 0,  1, 0, 32'h10,       32'h10,        1, 0, 4);
      vecs[12] = mk(0, 0, 0, 1, 32'h0,        26'h8,   0, 0,  1, 0, 32'h14,       32'h20,        1, 0, 5);
      vecs[13] = mk(1, 0, 0, 0, 32'h0,        26'h0,   0, 0,  0, 0, 32'h24,       32'h20,        1, 0, 5);
      vecs[14] = mk(1, 0, 0, 0, 32'h0,        26'h0,   1, 0,  0, 0, 32'h24,       32'h20,        1, 0, 5);
      vecs[15] = mk(1, 1, 1, 0, 32'h0,        26'h0,   0, 0,  0, 0, 32'h24,       32'h20,        1, 0, 5);
      vecs[16] = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 0,  1, 0, 32'h24,       32'h24,        1, 0, 6);
      vecs[17] = mk(0, 0, 0, 1, 32'h0,        26'h10,  0, 0,  1, 0, 32'h28,       32'h40,        1, 0, 7);
      vecs[18] = mk(0, 1, 1, 0, 32'hFFFFFFFC, 26'h0,   0, 0,  1, 1, 32'h44,       32'h34,        1, 0, 8);
      vecs[19] = mk(0, 0, 0, 1, 32'h0,        26'h10,  0, 0,  1, 0, 32'h38,       32'h40,        1, 0, 9);
      vecs[20] = mk(0, 1, 0, 0, 32'hFFFFFFFC, 26'h0,   0, 0,  1, 0, 32'h44,       32'h44,        1, 0, 10);
      vecs[21] = mk(0, 1, 1, 0, 32'h03FFFFEE, 26'h0,   0, 0,  1, 1, 32'h48,       32'h10000000,  1, 0, 11);
      vecs[22] = mk(0, 0, 1, 1, 32'h0,        26'h100, 0, 0,  1, 0, 32'h10000004, 32'h10000400,  1, 0, 12);
      vecs[23] = mk(0, 1, 1, 0, 32'h3BFFFF13, 26'h0,   0, 0,  1, 1, 32'h10000404, 32'h50,        1, 0, 13);
      vecs[24] = mk(1, 1, 1, 1, 32'h0,        26'h0,   0, 0,  0, 0, 32'h54,       32'h180,       3, 1, 13);
      vecs[25] = mk(0, 0, 0, 0, 32'h0,        26'h0,   1, 0,  0, 0, 32'h184,      32'h180,       3, 1, 13);
      vecs[26] = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 1,  0, 0, 32'h184,      32'h180,       1, 1, 13);
      vecs[27] = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 0,  1, 0, 32'h184,      32'h184,       1, 1, 14);
      vecs[28] = mk(0, 0, 0, 0, 32'h0,        26'h0,   0, 1,  1, 0, 32'h188,      32'h188,       1, 1, 15);
      vecs[29] = mk(0, 1, 0, 1, 32'h0,        26'h0,   0, 0,  0, 0, 32'h18C,      32'h180,       3, 1, 15);

      #1 rst_n = 1'b0;
      #6;
      checkOutput("reset pc", pc, 32'h0);
      checkOutput("reset state", 32'(state), 32'd0);
      checkOutput("reset trap_err", 32'(trapErr), 32'd0);
      checkOutput("reset instr_count", instrCount, 32'd0);
      checkOutput("reset instr_valid", 32'(instrValid), 32'd0);
      checkOutput("reset pc_src_sel", 32'(pcSrcSel), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         applyStimulus(i);
      end

      // Asynchronous reset while sitting in TRAP, away from any clock edge.
      stall = 0; branch = 0; zero = 0; jump = 0; haltReq = 0; resume = 0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midtrap reset pc", pc, 32'h0);
      checkOutput("midtrap reset state", 32'(state), 32'd0);
      checkOutput("midtrap reset trap_err", 32'(trapErr), 32'd0);
      checkOutput("midtrap reset instr_count", instrCount, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("reboot edge1 state", 32'(state), 32'd0);
      checkOutput("reboot edge1 pc", pc, 32'h0);
      @(posedge clk); #1;
      checkOutput("reboot edge2 state", 32'(state), 32'd1);
      checkOutput("reboot edge2 pc", pc, 32'h0);
      checkOutput("reboot edge2 instr_valid", 32'(instrValid), 32'd1);
      @(posedge clk); #1;
      checkOutput("reboot edge3 pc", pc, 32'h4);
      checkOutput("reboot edge3 instr_count", instrCount, 32'd1);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
